// File: rtl/hdmi_pkg.sv
// Shared HDMI InfoFrame definitions: AVI constants, packet byte indices,
// parser state encoding and the decoded AVI field bank layout.
package hdmi_pkg;

  localparam logic [7:0]  AVI_TYPE    = 8'h82;
  localparam logic [4:0]  AVI_LENGTH  = 5'd13;
  localparam logic [7:0]  AVI_VERSION = 8'd2;
  localparam logic [7:0]  AVI_VERSION_ALT = 8'd3;

  localparam int unsigned PKT_BYTES = 31;
  localparam int unsigned IDX_W     = 5;

  // Byte positions in the serial stream (HB0 = 0, PB0 = 3, PB27 = 30)
  localparam logic [IDX_W-1:0] IDX_HB1  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_HB2  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_PB1  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_PB2  = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_PB3  = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_PB4  = IDX_W'(7);
  localparam logic [IDX_W-1:0] IDX_PB5  = IDX_W'(8);
  localparam logic [IDX_W-1:0] IDX_PB13 = IDX_W'(16);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_SKIP
  } parser_state_t;

  typedef struct packed {
    logic [1:0] video_format;
    logic [1:0] scan_info;
    logic [1:0] colorimetry;
    logic [1:0] picture_aspect;
    logic       it_content;
    logic [1:0] rgb_quant;
    logic [6:0] vic;
    logic [1:0] ycc_quant;
    logic [1:0] content_type;
    logic [3:0] pixel_repetition;
  } avi_fields_t;

endpackage

// File: rtl/packet_checksum_acc.sv
// Modulo-256 byte accumulator for InfoFrame checksums. clear and add may be
// asserted together to restart the sum with the current byte. zero_c reports
// whether the sum including this cycle's byte is zero.
module packet_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic       zero_c
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  // Next sum: optional restart, then optional byte add
  always_comb begin
    sum_d = clear ? 8'd0 : sum_q;
    if (add) begin
      sum_d = sum_d + data;
    end
  end

  assign zero_c = (sum_d == 8'd0);

  // Sum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/avi_info_frame_parser.sv
// HDMI AVI InfoFrame sink decoder. Parses HB0..HB2 / PB0..PB27, validates
// header and checksum, and refreshes the decoded field bank on good frames.
// Optional macro AVI_PARSER_STATS_EN adds saturating good/bad/abort counters.
module avi_info_frame_parser
  import hdmi_pkg::*;
#(
  parameter logic [7:0] EXPECTED_VERSION = AVI_VERSION
`ifdef AVI_PARSER_STATS_EN
  , parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [7:0] pkt_byte,
  input  logic       pkt_valid,
  input  logic       pkt_sop,
  output logic       frame_update,
  output logic       frame_valid,
  output logic       checksum_error,
  output logic [1:0] video_format,
  output logic [1:0] scan_info,
  output logic [1:0] colorimetry,
  output logic [1:0] picture_aspect,
  output logic       it_content,
  output logic [1:0] rgb_quant,
  output logic [6:0] vic,
  output logic       pal,
  output logic [1:0] ycc_quant,
  output logic [1:0] content_type,
  output logic [3:0] pixel_repetition
`ifdef AVI_PARSER_STATS_EN
  , output logic [STAT_WIDTH-1:0] good_count
  , output logic [STAT_WIDTH-1:0] bad_count
  , output logic [STAT_WIDTH-1:0] abort_count
`endif
);

  parser_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bad_q, bad_d;
  avi_fields_t      stage_q, stage_d;
  avi_fields_t      bank_q, bank_d;
  logic             pal_q, pal_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             error_q, error_d;
  logic             acc_clear_c, acc_add_c, acc_zero_c, abort_c;

  packet_checksum_acc u_checksum (
    .clk    (clk_pixel),
    .rst    (reset),
    .clear  (acc_clear_c),
    .add    (acc_add_c),
    .data   (pkt_byte),
    .zero_c (acc_zero_c)
  );

  // Packet walk: header checks, staging capture, verdict after PB13
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    stage_d     = stage_q;
    bank_d      = bank_q;
    pal_d       = pal_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    error_d     = 1'b0;
    acc_clear_c = 1'b0;
    acc_add_c   = 1'b0;
    abort_c     = 1'b0;
    if (pkt_valid) begin
      if (pkt_sop) begin
        // A packet still awaiting its verdict is abandoned silently
        abort_c     = (state_q == ST_HDR) || (state_q == ST_BODY);
        acc_clear_c = 1'b1;
        acc_add_c   = 1'b1;
        idx_d       = IDX_W'(1);
        bad_d       = 1'b0;
        state_d     = (pkt_byte == AVI_TYPE) ? ST_HDR : ST_SKIP;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_HDR: begin
            acc_add_c = 1'b1;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_HB1 && pkt_byte != EXPECTED_VERSION && pkt_byte != AVI_VERSION_ALT) begin
              bad_d = 1'b1;
            end
            if (idx_q == IDX_HB2) begin
              if (pkt_byte[4:0] != AVI_LENGTH) begin
                bad_d = 1'b1;
              end
              state_d = ST_BODY;
            end
          end
          ST_BODY: begin
            acc_add_c = 1'b1;
            idx_d     = idx_q + IDX_W'(1);
            case (idx_q)
              IDX_PB1: begin
                stage_d.video_format = pkt_byte[6:5];
                stage_d.scan_info    = pkt_byte[1:0];
              end
              IDX_PB2: begin
                stage_d.colorimetry    = pkt_byte[7:6];
                stage_d.picture_aspect = pkt_byte[5:4];
              end
              IDX_PB3: begin
                stage_d.it_content = pkt_byte[7];
                stage_d.rgb_quant  = pkt_byte[3:2];
              end
              IDX_PB4: stage_d.vic = pkt_byte[6:0];
              IDX_PB5: begin
                stage_d.ycc_quant        = pkt_byte[7:6];
                stage_d.content_type     = pkt_byte[5:4];
                stage_d.pixel_repetition = pkt_byte[3:0];
              end
              default: ;
            endcase
            if (idx_q == IDX_PB13) begin
              state_d = ST_SKIP;
              if (acc_zero_c && !bad_q) begin
                bank_d   = stage_q;
                pal_d    = (stage_q.vic == 7'd17) || (stage_q.vic == 7'd18);
                valid_d  = 1'b1;
                update_d = 1'b1;
              end else begin
                error_d = 1'b1;
              end
            end
          end
          ST_SKIP: begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Parser and output bank registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      stage_q  <= '0;
      bank_q   <= '0;
      pal_q    <= 1'b0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      stage_q  <= stage_d;
      bank_q   <= bank_d;
      pal_q    <= pal_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      error_q  <= error_d;
    end
  end

  assign frame_update     = update_q;
  assign frame_valid      = valid_q;
  assign checksum_error   = error_q;
  assign video_format     = bank_q.video_format;
  assign scan_info        = bank_q.scan_info;
  assign colorimetry      = bank_q.colorimetry;
  assign picture_aspect   = bank_q.picture_aspect;
  assign it_content       = bank_q.it_content;
  assign rgb_quant        = bank_q.rgb_quant;
  assign vic              = bank_q.vic;
  assign pal              = pal_q;
  assign ycc_quant        = bank_q.ycc_quant;
  assign content_type     = bank_q.content_type;
  assign pixel_repetition = bank_q.pixel_repetition;

`ifdef AVI_PARSER_STATS_EN
  logic [STAT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [STAT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
  logic [STAT_WIDTH-1:0] abort_cnt_q, abort_cnt_d;

  // Saturating event counters, updated on the same edge as the pulses
  always_comb begin
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (update_d && !(&good_cnt_q)) good_cnt_d = good_cnt_q + STAT_WIDTH'(1);
    if (error_d && !(&bad_cnt_q)) bad_cnt_d = bad_cnt_q + STAT_WIDTH'(1);
    if (abort_c && !(&abort_cnt_q)) abort_cnt_d = abort_cnt_q + STAT_WIDTH'(1);
  end

  // Counter registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign good_count  = good_cnt_q;
  assign bad_count   = bad_cnt_q;
  assign abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_avi_info_frame_parser.sv
// Self-checking bench for avi_info_frame_parser: directed scenarios plus
// randomized packets against a byte-array reference model.
module tb_avi_info_frame_parser;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [7:0] pkt_byte;
  logic       pkt_valid;
  logic       pkt_sop;
  logic       frame_update, frame_valid, checksum_error;
  logic [1:0] video_format, scan_info, colorimetry, picture_aspect;
  logic       it_content;
  logic [1:0] rgb_quant;
  logic [6:0] vic;
  logic       pal;
  logic [1:0] ycc_quant, content_type;
  logic [3:0] pixel_repetition;
`ifdef AVI_PARSER_STATS_EN
  logic [15:0] good_count, bad_count, abort_count;
`endif

  avi_info_frame_parser dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .pkt_byte         (pkt_byte),
    .pkt_valid        (pkt_valid),
    .pkt_sop          (pkt_sop),
    .frame_update     (frame_update),
    .frame_valid      (frame_valid),
    .checksum_error   (checksum_error),
    .video_format     (video_format),
    .scan_info        (scan_info),
    .colorimetry      (colorimetry),
    .picture_aspect   (picture_aspect),
    .it_content       (it_content),
    .rgb_quant        (rgb_quant),
    .vic              (vic),
    .pal              (pal),
    .ycc_quant        (ycc_quant),
    .content_type     (content_type),
    .pixel_repetition (pixel_repetition)
`ifdef AVI_PARSER_STATS_EN
    , .good_count     (good_count)
    , .bad_count      (bad_count)
    , .abort_count    (abort_count)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: PB1..PB5 of the last good AVI packet, plus event tallies
  logic [7:0]  pkt [31];
  logic [7:0]  m_pb [1:5];
  logic        m_valid;
  int unsigned m_good, m_bad, m_abort;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 1; i <= 5; i++) m_pb[i] = 8'h00;
    m_valid = 1'b0;
    m_good  = 0;
    m_bad   = 0;
    m_abort = 0;
  endtask

  // Outputs must be plain bit slices of the last good packet's PB1..PB5
  task automatic check_fields(input string ctx);
    logic [7:0] b1, b2, b3, b4, b5;
    b1 = m_pb[1]; b2 = m_pb[2]; b3 = m_pb[3]; b4 = m_pb[4]; b5 = m_pb[5];
    check_eq({ctx, "_video_format"}, 32'(video_format), 32'(b1[6:5]));
    check_eq({ctx, "_scan_info"}, 32'(scan_info), 32'(b1[1:0]));
    check_eq({ctx, "_colorimetry"}, 32'(colorimetry), 32'(b2[7:6]));
    check_eq({ctx, "_aspect"}, 32'(picture_aspect), 32'(b2[5:4]));
    check_eq({ctx, "_it_content"}, 32'(it_content), 32'(b3[7]));
    check_eq({ctx, "_rgb_quant"}, 32'(rgb_quant), 32'(b3[3:2]));
    check_eq({ctx, "_vic"}, 32'(vic), 32'(b4[6:0]));
    check_eq({ctx, "_pal"}, 32'(pal), 32'((b4[6:0] == 7'd17) || (b4[6:0] == 7'd18)));
    check_eq({ctx, "_ycc_quant"}, 32'(ycc_quant), 32'(b5[7:6]));
    check_eq({ctx, "_content_type"}, 32'(content_type), 32'(b5[5:4]));
    check_eq({ctx, "_pix_rep"}, 32'(pixel_repetition), 32'(b5[3:0]));
    check_eq({ctx, "_frame_valid"}, 32'(frame_valid), 32'(m_valid));
  endtask

  // Fill pkt[] with random reserved bytes and a PB0 that zeroes the checksum
  task automatic build(input logic [7:0] hb0, input logic [7:0] hb1, input logic [7:0] hb2,
                       input logic [7:0] pb1, input logic [7:0] pb2, input logic [7:0] pb3,
                       input logic [7:0] pb4, input logic [7:0] pb5);
    logic [7:0] s;
    for (int i = 0; i < 31; i++) pkt[i] = 8'($urandom);
    pkt[0] = hb0; pkt[1] = hb1; pkt[2] = hb2;
    pkt[4] = pb1; pkt[5] = pb2; pkt[6] = pb3; pkt[7] = pb4; pkt[8] = pb5;
    s = 8'h00;
    for (int i = 0; i < 17; i++) if (i != 3) s = s + pkt[i];
    pkt[3] = 8'h00 - s;
  endtask

  // Drive pkt[] byte by byte; abort_at >= 0 stops before that index so the next
  // packet's HB0 acts as the aborting sop. Checks pulses after every edge.
  task automatic send_packet(input int abort_at, input bit stalls, input string ctx);
    logic [7:0] s;
    bit         is_avi, good;
    for (int i = 0; i < 31; i++) begin
      if (i == abort_at) begin
        if (pkt[0] == 8'h82 && i <= 16) m_abort++;
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        return;
      end
      if (stalls) begin
        for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
          pkt_valid = 1'b0;
          pkt_sop   = 1'($urandom_range(0, 1));
          pkt_byte  = 8'($urandom);
          @(posedge clk_pixel); #1;
          check_eq({ctx, "_stall_update"}, 32'(frame_update), 32'd0);
          check_eq({ctx, "_stall_error"}, 32'(checksum_error), 32'd0);
        end
      end
      pkt_valid = 1'b1;
      pkt_sop   = (i == 0);
      pkt_byte  = pkt[i];
      @(posedge clk_pixel); #1;
      if (i == 16) begin
        s = 8'h00;
        for (int j = 0; j < 17; j++) s = s + pkt[j];
        is_avi = (pkt[0] == 8'h82);
        good   = is_avi && (pkt[1] == 8'd2 || pkt[1] == 8'd3) && (pkt[2][4:0] == 5'd13) && (s == 8'h00);
        if (good) begin
          for (int j = 1; j <= 5; j++) m_pb[j] = pkt[j + 3];
          m_valid = 1'b1;
          m_good++;
        end else if (is_avi) begin
          m_bad++;
        end
        check_eq({ctx, "_update"}, 32'(frame_update), 32'(good));
        check_eq({ctx, "_error"}, 32'(checksum_error), 32'(is_avi && !good));
        check_fields(ctx);
      end else begin
        check_eq({ctx, "_no_update"}, 32'(frame_update), 32'd0);
        check_eq({ctx, "_no_error"}, 32'(checksum_error), 32'd0);
      end
    end
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
  endtask

  task automatic idle(input int n);
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pixel); #1;
    end
  endtask

`ifdef AVI_PARSER_STATS_EN
  task automatic check_stats(input string ctx);
    check_eq({ctx, "_good_count"}, 32'(good_count), m_good);
    check_eq({ctx, "_bad_count"}, 32'(bad_count), m_bad);
    check_eq({ctx, "_abort_count"}, 32'(abort_count), m_abort);
  endtask
`endif

  initial begin
    int kind;
    logic [7:0] hb0, hb1, hb2, pb4;

    reset     = 1'b1;
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_byte  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    #1;
    check_eq("reset_update", 32'(frame_update), 32'd0);
    check_eq("reset_error", 32'(checksum_error), 32'd0);
    check_fields("reset");
    reset = 1'b0;
    idle(2);

    // Good frame, VIC 17 (PAL)
    build(8'h82, 8'h02, 8'h0D, 8'h00, 8'h08, 8'h00, 8'd17, 8'h00);
    send_packet(-1, 1'b0, "good17");
    check_eq("good17_vic_const", 32'(vic), 32'd17);
    check_eq("good17_pal_const", 32'(pal), 32'd1);

    // Same frame with PB0 off by one
    pkt[3] = pkt[3] + 8'd1;
    send_packet(-1, 1'b0, "badsum");
    check_eq("badsum_vic_hold", 32'(vic), 32'd17);
    check_eq("badsum_valid_hold", 32'(frame_valid), 32'd1);

    // Audio InfoFrame is ignored; next AVI packet back-to-back
    build(8'h84, 8'h01, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    send_packet(-1, 1'b0, "audio");
    build(8'h82, 8'h03, 8'hED, 8'h41, 8'hA5, 8'h8C, 8'd18, 8'h6B);
    send_packet(-1, 1'b0, "after_audio");

    // Wrong length with consistent checksum
    build(8'h82, 8'h02, 8'h0E, 8'h20, 8'h10, 8'h00, 8'd4, 8'h00);
    send_packet(-1, 1'b0, "badlen");

    // Abort at PB7, then a good VIC 2 frame
    build(8'h82, 8'h02, 8'h0D, 8'h60, 8'h00, 8'h00, 8'd33, 8'h00);
    send_packet(10, 1'b0, "abort");
    build(8'h82, 8'h02, 8'h0D, 8'h00, 8'h18, 8'h00, 8'd2, 8'h00);
    send_packet(-1, 1'b0, "post_abort");
    check_eq("post_abort_vic_const", 32'(vic), 32'd2);
    check_eq("post_abort_pal_const", 32'(pal), 32'd0);
`ifdef AVI_PARSER_STATS_EN
    check_eq("abort_count_const", 32'(abort_count), 32'd1);
`endif
    idle(3);

    // Stalled good frame, then reset during PB10 of the next one
    build(8'h82, 8'h02, 8'h0D, 8'h63, 8'hDA, 8'h8C, 8'd19, 8'hE5);
    send_packet(-1, 1'b1, "stalled");
    build(8'h82, 8'h02, 8'h0D, 8'h21, 8'h50, 8'h04, 8'd5, 8'h13);
    send_packet(13, 1'b1, "pre_reset");
    pkt_valid = 1'b1;
    pkt_byte  = pkt[13];
    reset     = 1'b1;
    #2;
    model_reset();
    check_fields("async_reset");
    @(posedge clk_pixel); #1;
    reset     = 1'b0;
    pkt_valid = 1'b0;
    check_eq("post_reset_update", 32'(frame_update), 32'd0);
    check_eq("post_reset_error", 32'(checksum_error), 32'd0);
    check_fields("post_reset");
    idle(1);
    // A fresh packet decoding correctly shows the parser is back in IDLE
    build(8'h82, 8'h02, 8'h0D, 8'h42, 8'h90, 8'h0C, 8'd17, 8'h51);
    send_packet(-1, 1'b0, "after_reset");

    // Randomized packet mix
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 6);
      hb0  = 8'h82;
      hb1  = $urandom_range(0, 1) ? 8'd2 : 8'd3;
      hb2  = {3'($urandom), 5'd13};
      pb4  = $urandom_range(0, 1) ? 8'($urandom_range(16, 19)) : 8'($urandom);
      if (kind == 2) begin
        hb0 = 8'($urandom);
        if (hb0 == 8'h82) hb0 = 8'h81;
      end
      if (kind == 3) begin
        hb1 = 8'($urandom);
        if (hb1 == 8'd2 || hb1 == 8'd3) hb1 = 8'd1;
      end
      if (kind == 4) hb2 = {3'($urandom), 5'($urandom_range(0, 12))};
      build(hb0, hb1, hb2, 8'($urandom), 8'($urandom), 8'($urandom), pb4, 8'($urandom));
      if (kind == 1) pkt[$urandom_range(3, 16)] ^= 8'(1 << $urandom_range(0, 7));
      send_packet((kind == 5) ? int'($urandom_range(1, 30)) : -1, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    build(8'h82, 8'h02, 8'h0D, 8'h01, 8'h02, 8'h03, 8'd18, 8'h05);
    send_packet(-1, 1'b0, "final");
    idle(2);
    check_fields("end");
`ifdef AVI_PARSER_STATS_EN
    check_stats("end");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
